// File: rtl/pipe_stage_hs_pkg.sv
// Shared pipeline definitions: default payload widths, the NOP bubble value
// and the stage occupancy encoding used by the handshaked stage registers.
package pipe_stage_hs_pkg;

  localparam int PIPE_INSTR_W = 32;
  localparam int PIPE_PC_W    = 32;

  // Instruction word driven downstream whenever the stage holds nothing.
  localparam logic [31:0] PIPE_NOP = 32'h0000_0000;

  // Occupancy of a stage: nothing held, main register full, main and skid full.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

  // A stage can take a new word unless both of its registers are occupied.
  function automatic logic stage_accepts(input stage_state_e st);
    return (st != ST_TWO);
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One valid+payload register of a pipeline stage. Load wins over clear.
// The instruction payload is never reset because consumers gate it with
// valid; the PC payload is loaded from a side input during reset so the
// downstream PC+4 is always defined.
module pipe_skid_slot
  import pipe_stage_hs_pkg::*;
#(
  parameter int INSTR_W = PIPE_INSTR_W,
  parameter int PC_W    = PIPE_PC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pcplus_i,
  input  logic [PC_W-1:0]    rst_pcplus_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pcplus_o
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pcplus_q, pcplus_d;

  // Next-state selection: load a new word, drop the held one, or keep it.
  always_comb begin
    valid_d  = valid_q;
    instr_d  = instr_q;
    pcplus_d = pcplus_q;
    if (load_i) begin
      valid_d  = 1'b1;
      instr_d  = instr_i;
      pcplus_d = pcplus_i;
    end else if (clear_i) begin
      valid_d  = 1'b0;
    end
  end

  // Valid flag and PC payload, with reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      pcplus_q <= rst_pcplus_i;
    end else begin
      valid_q  <= valid_d;
      pcplus_q <= pcplus_d;
    end
  end

  // Instruction payload, reset-free.
  always_ff @(posedge clk) begin
    instr_q <= instr_d;
  end

  assign valid_o  = valid_q;
  assign instr_o  = instr_q;
  assign pcplus_o = pcplus_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Handshaked pipeline-stage register carrying an instruction and its PC+4.
//
// Handshake: a word moves across an interface on a rising edge where both
// valid and ready are 1; valid never depends combinationally on ready, and a
// producer may present a word regardless of ready.
//
// SKID != 0: main + skid register, in_ready is registered (state != TWO) so
// backpressure does not ripple combinationally upstream. The skid word is
// always promoted to main before any newer word, preserving order.
// SKID == 0: main register only, in_ready = out_ready | ~out_valid.
//
// flush empties the stage (the word offered in that cycle is consumed and
// dropped); an outgoing transfer in the same cycle still completes.
// stall_cnt counts edges with out_valid=1 and out_ready=0, saturating.
module pipe_stage_hs
  import pipe_stage_hs_pkg::*;
#(
  parameter int                 INSTR_W = PIPE_INSTR_W,
  parameter int                 PC_W    = PIPE_PC_W,
  parameter int                 SKID    = 1,
  parameter logic [INSTR_W-1:0] NOP     = INSTR_W'(PIPE_NOP),
  parameter int                 CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pcplus,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pcplus,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [1:0]         dbg_state
);

  logic               in_fire;
  logic               out_fire;
  logic               main_load;
  logic               main_clear;
  logic               main_valid;
  logic [INSTR_W-1:0] main_instr;
  logic [PC_W-1:0]    main_pc;
  logic [INSTR_W-1:0] main_instr_d;
  logic [PC_W-1:0]    main_pc_d;
  logic [CNT_W-1:0]   stall_q, stall_d;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid & out_ready;

  pipe_skid_slot #(
    .INSTR_W (INSTR_W),
    .PC_W    (PC_W)
  ) u_main (
    .clk          (clk),
    .rst          (rst),
    .load_i       (main_load),
    .clear_i      (main_clear),
    .instr_i      (main_instr_d),
    .pcplus_i     (main_pc_d),
    .rst_pcplus_i (in_pcplus),
    .valid_o      (main_valid),
    .instr_o      (main_instr),
    .pcplus_o     (main_pc)
  );

  if (SKID != 0) begin : g_skid
    stage_state_e       state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               skid_load, skid_clear, skid_valid, main_from_skid;
    logic [INSTR_W-1:0] skid_instr;
    logic [PC_W-1:0]    skid_pc;

    pipe_skid_slot #(
      .INSTR_W (INSTR_W),
      .PC_W    (PC_W)
    ) u_skid (
      .clk          (clk),
      .rst          (rst),
      .load_i       (skid_load),
      .clear_i      (skid_clear),
      .instr_i      (in_instr),
      .pcplus_i     (in_pcplus),
      .rst_pcplus_i (in_pcplus),
      .valid_o      (skid_valid),
      .instr_o      (skid_instr),
      .pcplus_o     (skid_pc)
    );

    // Occupancy FSM: decides next state and which register loads or clears.
    always_comb begin
      state_d        = state_q;
      main_load      = 1'b0;
      main_clear     = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      skid_clear     = 1'b0;
      if (flush) begin
        state_d    = ST_EMPTY;
        main_clear = 1'b1;
        skid_clear = 1'b1;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (in_fire) begin
              state_d   = ST_ONE;
              main_load = 1'b1;
            end
          end
          ST_ONE: begin
            if (in_fire && out_fire) begin
              main_load = 1'b1;
            end else if (in_fire) begin
              state_d   = ST_TWO;
              skid_load = 1'b1;
            end else if (out_fire) begin
              state_d    = ST_EMPTY;
              main_clear = 1'b1;
            end
          end
          ST_TWO: begin
            if (out_fire) begin
              state_d        = ST_ONE;
              main_load      = 1'b1;
              main_from_skid = 1'b1;
              skid_clear     = 1'b1;
            end
          end
          default: begin
            state_d    = ST_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
          end
        endcase
      end
      in_ready_d = stage_accepts(state_d);
    end

    // State and registered ready.
    always_ff @(posedge clk) begin
      if (!rst) begin
        state_q    <= ST_EMPTY;
        in_ready_q <= 1'b1;
      end else begin
        state_q    <= state_d;
        in_ready_q <= in_ready_d;
      end
    end

    assign in_ready     = in_ready_q;
    assign main_instr_d = (main_from_skid && skid_valid) ? skid_instr : in_instr;
    assign main_pc_d    = (main_from_skid && skid_valid) ? skid_pc : in_pcplus;
    assign dbg_state    = state_q;
  end else begin : g_noskid
    // Single register: load on transfer in, empty on transfer out alone.
    always_comb begin
      main_load  = 1'b0;
      main_clear = 1'b0;
      if (flush) begin
        main_clear = 1'b1;
      end else if (in_fire) begin
        main_load  = 1'b1;
      end else if (out_fire) begin
        main_clear = 1'b1;
      end
    end

    assign in_ready     = out_ready | ~main_valid;
    assign main_instr_d = in_instr;
    assign main_pc_d    = in_pcplus;
    assign dbg_state    = main_valid ? 2'(ST_ONE) : 2'(ST_EMPTY);
  end

  // Stall counter next value: step while a held word is refused, stop at all-ones.
  always_comb begin
    stall_d = stall_q;
    if (main_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign out_valid  = main_valid;
  assign out_instr  = main_valid ? main_instr : NOP;
  assign out_pcplus = main_pc;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: three instances share one stimulus stream
// (SKID=1, SKID=0, SKID=1 with a 4-bit stall counter). A capacity-based
// queue model predicts every output of every instance each cycle.
module tb_pipe_stage_hs;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pcplus;

  logic        rdy0, rdy1, rdy2, vld0, vld1, vld2;
  logic [31:0] instr0, instr1, instr2, pc0, pc1, pc2;
  logic [15:0] stall0, stall1;
  logic [3:0]  stall2;
  logic [1:0]  st0, st1, st2;

  always #5 clk = ~clk;

  pipe_stage_hs #(.SKID(1), .CNT_W(16)) u_s1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
    .in_instr(in_instr), .in_pcplus(in_pcplus), .out_valid(vld0), .out_ready(out_ready),
    .out_instr(instr0), .out_pcplus(pc0), .stall_cnt(stall0), .dbg_state(st0)
  );

  pipe_stage_hs #(.SKID(0), .CNT_W(16)) u_s0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .in_instr(in_instr), .in_pcplus(in_pcplus), .out_valid(vld1), .out_ready(out_ready),
    .out_instr(instr1), .out_pcplus(pc1), .stall_cnt(stall1), .dbg_state(st1)
  );

  pipe_stage_hs #(.SKID(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy2),
    .in_instr(in_instr), .in_pcplus(in_pcplus), .out_valid(vld2), .out_ready(out_ready),
    .out_instr(instr2), .out_pcplus(pc2), .stall_cnt(stall2), .dbg_state(st2)
  );

  // ---------------- scoreboard / reference model ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  bit          chk_en = 1'b0;
  logic [63:0] exp_q[3][$];          // held words {instr, pcplus}, oldest first
  int          m_stall[3];
  int          m_max[3] = '{65535, 65535, 15};
  logic [31:0] m_pc[3];
  bit          rdy_exp[3];
  logic [31:0] seen_q[$];            // words observed leaving instance 0
  bit          acc0, acc1;
  int          n_acc1, n_emit1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Capacity rules: the skid variants hold up to two words and accept while
  // not full; the plain register accepts when empty or when draining this cycle.
  function automatic bit model_ready(input int k);
    if (k == 1) return out_ready || (exp_q[1].size() == 0);
    return exp_q[k].size() < 2;
  endfunction

  task automatic model_update(input int k);
    bit          ofire, ifire;
    logic [63:0] w;
    ofire = (exp_q[k].size() > 0) && out_ready;
    ifire = in_valid && rdy_exp[k];
    if (!rst) begin
      exp_q[k].delete();
      m_stall[k] = 0;
      m_pc[k]    = in_pcplus;
    end else begin
      if ((exp_q[k].size() > 0) && !out_ready && (m_stall[k] < m_max[k])) m_stall[k]++;
      if (flush) begin
        exp_q[k].delete();
      end else begin
        if (ofire) w = exp_q[k].pop_front();
        if (ifire) exp_q[k].push_back({in_instr, in_pcplus});
      end
      if (exp_q[k].size() > 0) begin
        w = exp_q[k][0];
        m_pc[k] = w[31:0];
      end
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step();
    logic        o_vld[3], o_rdy[3];
    logic [31:0] o_instr[3], o_pc[3];
    logic [15:0] o_stall[3];
    logic [1:0]  o_st[3];
    logic [63:0] head;
    bit          has;
    @(negedge clk);
    o_vld   = '{vld0, vld1, vld2};
    o_rdy   = '{rdy0, rdy1, rdy2};
    o_instr = '{instr0, instr1, instr2};
    o_pc    = '{pc0, pc1, pc2};
    o_stall = '{stall0, stall1, {12'h000, stall2}};
    o_st    = '{st0, st1, st2};
    for (int k = 0; k < 3; k++) begin
      rdy_exp[k] = model_ready(k);
      if (chk_en) begin
        has  = exp_q[k].size() > 0;
        head = has ? exp_q[k][0] : 64'h0;
        check($sformatf("u%0d.out_valid", k), 64'(o_vld[k]), 64'(has));
        check($sformatf("u%0d.out_instr", k), 64'(o_instr[k]), has ? 64'(head[63:32]) : 64'h0);
        check($sformatf("u%0d.out_pcplus", k), 64'(o_pc[k]), 64'(m_pc[k]));
        check($sformatf("u%0d.in_ready", k), 64'(o_rdy[k]), 64'(rdy_exp[k]));
        check($sformatf("u%0d.stall_cnt", k), 64'(o_stall[k]), 64'(m_stall[k]));
        check($sformatf("u%0d.state", k), 64'(o_st[k]), 64'(exp_q[k].size()));
      end
    end
    acc0 = in_valid && rdy_exp[0] && rst;
    acc1 = in_valid && rdy_exp[1] && rst && !flush;
    if (chk_en && rst && o_vld[0] && out_ready) seen_q.push_back(o_instr[0]);
    if (chk_en && acc1) n_acc1++;
    if (chk_en && rst && o_vld[1] && out_ready) n_emit1++;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_update(k);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    in_valid  = 1'b1;
    in_instr  = instr;
    in_pcplus = pc;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] words[3];
    int          idx;

    // Reset with a known PC+4 on the input.
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'h0; in_pcplus = 32'h0000_0104;
    step();
    chk_en = 1'b1;
    check("rst_valid", 64'(vld0), 64'h0);
    check("rst_instr", 64'(instr0), 64'h0);
    check("rst_pcplus", 64'(pc0), 64'h0000_0104);
    check("rst_in_ready", 64'(rdy0), 64'h1);
    check("rst_stall", 64'(stall0), 64'h0);
    check("rst_pcplus_s0", 64'(pc1), 64'h0000_0104);
    rst = 1'b1;
    step();

    // Streaming with no backpressure: 1-cycle latency, ready stays high.
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      offer(32'h2001_0000 + 32'(i), 32'h0000_1000 + 32'(4 * i));
      step();
      check("stream_out", 64'(instr0), 64'(32'h2001_0000 + 32'(i)));
      check("stream_ready", 64'(rdy0), 64'h1);
    end
    in_valid = 1'b0;
    step();
    step();

    // Backpressure: two words fill main+skid, the third waits upstream.
    words = '{32'h3001_0001, 32'h3001_0002, 32'h3001_0003};
    seen_q.delete();
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      offer(words[idx], 32'h0000_3000 + 32'(4 * idx));
      step();
      if (acc0) idx++;
      if (c == 1) check("skid_ready_low", 64'(rdy0), 64'h0);
    end
    check("skid_held_upstream", 64'(idx), 64'd2);
    check("stall_four", 64'(stall0), 64'd4);
    check("stall_four_cnt4", 64'(stall2), 64'd4);
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (idx < 3) offer(words[idx], 32'h0000_3000 + 32'(4 * idx));
      else in_valid = 1'b0;
      step();
      if (acc0) idx++;
    end
    in_valid = 1'b0;
    check("skid_count", 64'(seen_q.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("skid_order%0d", i),
            64'((i < seen_q.size()) ? seen_q[i] : 32'hFFFF_FFFF), 64'(words[i]));

    // Flush while full with a word on the input.
    out_ready = 1'b0;
    offer(32'h4001_0001, 32'h0000_4104);
    step();
    offer(32'h4001_0002, 32'h0000_4108);
    step();
    check("flush_pre_two", 64'(st0), 64'd2);
    flush = 1'b1;
    offer(32'h4001_0003, 32'h0000_410C);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", 64'(vld0), 64'h0);
    check("flush_nop", 64'(instr0), 64'h0);
    check("flush_pcplus", 64'(pc0), 64'h0000_4104);
    check("flush_ready", 64'(rdy0), 64'h1);
    seen_q.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) step();
    check("flush_nothing_out", 64'(seen_q.size()), 64'd0);

    // Reset in the middle of a stall with both registers full.
    out_ready = 1'b0;
    offer(32'h5001_0001, 32'h0000_5104);
    step();
    offer(32'h5001_0002, 32'h0000_5108);
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    in_pcplus = 32'h0BAD_0104;
    step();
    rst = 1'b1;
    check("rst_mid_stall", 64'(stall0), 64'h0);
    check("rst_mid_valid", 64'(vld0), 64'h0);
    check("rst_mid_pcplus", 64'(pc0), 64'h0BAD_0104);
    check("rst_mid_ready", 64'(rdy0), 64'h1);
    seen_q.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) step();
    check("rst_dropped", 64'(seen_q.size()), 64'd0);

    // Long stall: 4-bit counter saturates, 16-bit counter keeps counting.
    out_ready = 1'b0;
    offer(32'h6001_0001, 32'h0000_6104);
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 20; c++) step();
    check("sat_cnt4", 64'(stall2), 64'hF);
    check("sat_cnt16", 64'(stall0), 64'd20);
    out_ready = 1'b1;
    step();
    step();

    // Plain register: ready follows out_ready in the same cycle while full.
    n_acc1 = 0;
    n_emit1 = 0;
    idx = 0;
    for (int c = 0; c < 16; c++) begin
      out_ready = (c % 2 == 0);
      offer(32'h7001_0000 + 32'(idx), 32'h0000_7000 + 32'(4 * idx));
      #1;
      if (vld1) check("s0_ready_tracks", 64'(rdy1), 64'(out_ready));
      step();
      if (acc1) idx++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) step();
    check("s0_accepted", 64'(n_acc1), 64'd8);
    check("s0_conserved", 64'(n_emit1), 64'(n_acc1));

    // Random traffic with occasional flush and reset.
    for (int c = 0; c < 1500; c++) begin
      rst       = ($urandom_range(0, 199) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      in_valid  = 1'($urandom_range(0, 1));
      in_instr  = $urandom;
      in_pcplus = $urandom;
      step();
    end
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_hs.md
Name: pipe_stage_hs

Overview:
- Parametrised handshaked pipeline-stage register. It is the next-generation replacement for the fixed-width, enable-only stage registers between pipeline stages (IF/ID first, then ID/EX, EX/MEM, MEM/WB).
- Carries an instruction word plus a PC+4 word, with a valid/ready handshake and an optional 2-entry skid buffer so backpressure is registered.
- Adds a flush input that inserts NOP bubbles, and a stall-cycle counter for performance monitoring.

Parameters:
- INSTR_W, 32, width of the instruction payload.
- PC_W, 32, width of the PC+4 payload.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- NOP, 32'h0000_0000 (INSTR_W bits), instruction value driven on out_instr when the stage is empty, flushed or in reset.
- CNT_W, 16, width of the stall counter.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-low reset.
- flush, input, 1, discard all held entries this cycle.
- in_valid, input, 1, upstream has a word.
- in_ready, output, 1, stage can accept a word.
- in_instr, input, INSTR_W, upstream instruction.
- in_pcplus, input, PC_W, upstream PC+4.
- out_valid, output, 1, out_instr/out_pcplus hold a live word.
- out_ready, input, 1, downstream accepts.
- out_instr, output, INSTR_W, held instruction; NOP when not valid.
- out_pcplus, output, PC_W, held PC+4; retained when not valid.
- stall_cnt, output, CNT_W, count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- A transfer in occurs when in_valid and in_ready are both 1 on a rising edge. A transfer out occurs when out_valid and out_ready are both 1 on a rising edge. Latency in→out is 1 cycle.
- Reset (rst=0 at a rising edge):
  - out_valid=0, out_instr=NOP, stall_cnt=0, skid entry invalid.
  - out_pcplus loads in_pcplus, so PC+4 stays defined for branch logic.
  - in_ready=1 in the cycle after reset.
  - Reset overrides flush and any transfer. Reset asserted mid-stall drops all held words.
- SKID=1 states:
  - EMPTY: main and skid both empty.
  - ONE: main full.
  - TWO: main and skid full.
  - in_ready is a register, 1 exactly when the state is not TWO.
- SKID=1 transitions (non-flush cycles):
  - EMPTY + in → ONE (main ← in).
  - ONE + in, no out → TWO (skid ← in).
  - ONE + in + out → ONE (main ← in).
  - ONE + out, no in → EMPTY.
  - TWO + out → ONE (main ← skid). No input is accepted in TWO.
  - Ordering is preserved: the skid word is always emitted before any newer word.
- SKID=0:
  - in_ready = out_ready OR NOT out_valid, combinational.
  - Single register; load on transfer in; clear valid on transfer out with no transfer in.
- flush=1 (rst=1):
  - Next state is EMPTY and out_instr becomes NOP.
  - out_pcplus retains its value.
  - A word presented in the same cycle is discarded even if in_ready=1; upstream must treat it as consumed.
  - A transfer out in the flush cycle still completes.
  - stall_cnt is unaffected by flush.
- stall_cnt increments by 1 on every edge where out_valid=1 and out_ready=0. It saturates at all-ones; it does not wrap.
- When not valid, out_instr = NOP. The payload registers themselves need not be cleared.
- Payload widths are independent; no arithmetic on the payload.

Decomposition:
- Shared pipeline package:
  - PIPE_NOP constant (32'h0000_0000).
  - Default INSTR_W/PC_W.
  - Stage-state encoding EMPTY=2'd0, ONE=2'd1, TWO=2'd2 as a localparam set.
- One natural sub-module: pipe_skid_slot, a single valid+payload register with load/clear, instantiated as main and skid.
- stall_cnt logic stays inline.

Test Plan:
- Reset with in_pcplus=32'h0000_0104 → out_valid=0, out_instr=32'h0, out_pcplus=32'h0000_0104, in_ready=1, stall_cnt=0.
- Stream 4 words (instr 32'h2001_0001..0004) with out_ready=1 → each appears 1 cycle later in order; in_ready stays 1 throughout.
- SKID=1, hold out_ready=0 while sending 3 words:
  - Words 1 and 2 are accepted; in_ready=0 the cycle after the 2nd is accepted.
  - Word 3 is held upstream.
  - Release out_ready → order 1, 2, 3 is preserved; stall_cnt equals the number of stalled cycles (e.g. 4).
- flush while in TWO with in_valid=1 → next cycle out_valid=0, out_instr=NOP, out_pcplus unchanged, in_ready=1; neither held word nor the input word ever emerges.
- Reset asserted (rst=0) mid-stall in TWO → all words dropped, stall_cnt=0.
- CNT_W=4, hold a stall for 20 cycles → stall_cnt saturates at 4'hF.
- SKID=0 with out_valid=1 and out_ready toggling 1/0 → in_ready tracks out_ready in the same cycle; no word is lost or duplicated.
